locker_access_controller: RTL and testbench

- Front-end sequencer for the digital locker. It takes single BCD digits from the keypad over a valid/ready handshake and assembles a 2-digit code.
- It runs the attempt/lockout/master-unlock sequence, drives the unlock strobe and the 2-bit locker status code, and auto-relocks after a hold time.
- It sits between the keypad scanner and the lock actuator.

---
 rtl/locker_access_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_locker_access_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/locker_access_controller.sv
// locker_access_controller
//   Keypad front-end sequencer for the digital locker. Collects BCD digits over
//   a valid/ready handshake into a DIGITS-digit code, checks it against the user
//   PIN, counts consecutive wrong attempts, enters LOCKOUT after MAX_TRIES
//   failures (released only by MASTER_PIN), and drives the lock actuator for
//   UNLOCK_CYCLES cycles (or until relock) on a correct code.
//
//   Optional feature macro: LOCKER_PIN_CHANGE_EN
//     When defined, a complete code entered while OPEN replaces the user PIN.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   synchronous active-high reset
//   key_valid    in   key_digit is presented
//   key_digit    in   [3:0] BCD digit
//   key_ready    out  controller accepts a digit this cycle
//   key_enter    in   submit the code (pulse)
//   key_clear    in   discard the partial entry
//   relock       in   door closed, relock immediately
//   unlocked     out  lock actuator drive
//   locked_out   out  high in LOCKOUT
//   status       out  [1:0] 00 idle, 01 warning/locked, 10 master release, 11 open
//   fail_count   out  [1:0] consecutive wrong attempts
//   attempt_err  out  pulse on a wrong code
//   bad_digit    out  pulse on an accepted non-BCD digit
//   pin_changed  out  pulse on a PIN update (feature build only)
module locker_access_controller #(
  parameter int                 DIGITS        = 2,
  parameter int                 MAX_TRIES     = 3,
  parameter int                 UNLOCK_CYCLES = 16,
  parameter logic [4*DIGITS-1:0] DEFAULT_PIN  = 8'h03,
  parameter logic [4*DIGITS-1:0] MASTER_PIN   = 8'h80
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic       key_ready,
  input  logic       key_enter,
  input  logic       key_clear,
  input  logic       relock,
  output logic       unlocked,
  output logic       locked_out,
  output logic [1:0] status,
  output logic [1:0] fail_count,
  output logic       attempt_err,
  output logic       bad_digit,
  output logic       pin_changed
);

  localparam int CODE_W = 4 * DIGITS;
  localparam int CW     = $clog2(DIGITS + 1);
  localparam int TW     = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;
  localparam logic [CW-1:0] FULL     = CW'(DIGITS);
  localparam logic [TW-1:0] T_LAST   = TW'(UNLOCK_CYCLES - 1);
  localparam logic [1:0]    F_MAX    = 2'(MAX_TRIES);
  localparam logic [1:0]    F_WARN   = 2'(MAX_TRIES - 1);

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, LOCKOUT} state_t;

  state_t              state, state_d;
  logic [CODE_W-1:0]   code, code_d;
  logic [CW-1:0]       count, count_d;
  logic [1:0]          fail_d;
  logic [TW-1:0]       timer, timer_d;
  logic                full, full_d;     // count==DIGITS captured at key_enter
  logic [1:0]          status_d;
  logic                err_d, bad_d, release_d;
  logic                accept, digit_ok;
  logic [CODE_W-1:0]   pin_reg;

`ifdef LOCKER_PIN_CHANGE_EN
  logic [CODE_W-1:0]   pin_d;
  logic                pchg_d;
`else
  assign pin_reg     = DEFAULT_PIN;
  assign pin_changed = 1'b0;
`endif

  // Ready is a pure decode of the state register.
  always_comb begin
    unique case (state)
      IDLE, ENTRY, LOCKOUT: key_ready = 1'b1;
`ifdef LOCKER_PIN_CHANGE_EN
      OPEN:                 key_ready = 1'b1;
`endif
      default:              key_ready = 1'b0;
    endcase
  end

  assign unlocked   = (state == OPEN);
  assign locked_out = (state == LOCKOUT);

  assign accept   = key_valid & key_ready;
  // Clear and enter both outrank a digit presented in the same cycle.
  assign digit_ok = accept & (key_digit <= 4'd9) & ~key_clear & ~key_enter & (count != FULL);

  always_comb begin
    state_d   = state;
    code_d    = code;
    count_d   = count;
    fail_d    = fail_count;
    timer_d   = timer;
    full_d    = full;
    err_d     = 1'b0;
    bad_d     = accept & (key_digit > 4'd9);
    release_d = 1'b0;
`ifdef LOCKER_PIN_CHANGE_EN
    pin_d     = pin_reg;
    pchg_d    = 1'b0;
`endif

    if (digit_ok) begin
      code_d  = {code[CODE_W-5:0], key_digit};
      count_d = count + CW'(1);
    end

    unique case (state)
      IDLE, ENTRY: begin
        if (key_clear) begin
          code_d  = '0;
          count_d = '0;
          state_d = IDLE;
        end else if (key_enter) begin
          full_d  = (count == FULL);
          state_d = CHECK;
        end else if (digit_ok) begin
          state_d = ENTRY;
        end
      end

      CHECK: begin
        code_d  = '0;
        count_d = '0;
        if (full && code == pin_reg) begin
          state_d = OPEN;
          fail_d  = '0;
          timer_d = '0;
        end else begin
          fail_d  = fail_count + 2'd1;
          err_d   = 1'b1;
          state_d = (fail_count + 2'd1 == F_MAX) ? LOCKOUT : IDLE;
        end
      end

      OPEN: begin
        timer_d = timer + TW'(1);
        if (relock || timer == T_LAST) begin
          state_d = IDLE;
          timer_d = '0;
          code_d  = '0;
          count_d = '0;
        end
`ifdef LOCKER_PIN_CHANGE_EN
        else if (key_clear) begin
          code_d  = '0;
          count_d = '0;
        end else if (key_enter && count == FULL) begin
          pin_d   = code;
          pchg_d  = 1'b1;
          code_d  = '0;
          count_d = '0;
          timer_d = '0;
        end
`endif
      end

      LOCKOUT: begin
        // Master PIN is compared directly; no CHECK cycle and no attempt_err.
        if (key_clear || key_enter) begin
          code_d  = '0;
          count_d = '0;
        end
        if (!key_clear && key_enter && count == FULL && code == MASTER_PIN) begin
          state_d   = IDLE;
          fail_d    = '0;
          release_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (state_d == OPEN)                                status_d = 2'b11;
    else if (release_d)                                 status_d = 2'b10;
    else if (state_d == LOCKOUT || fail_d == F_WARN)    status_d = 2'b01;
    else                                                status_d = 2'b00;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      code        <= '0;
      count       <= '0;
      fail_count  <= '0;
      timer       <= '0;
      full        <= 1'b0;
      status      <= 2'b00;
      attempt_err <= 1'b0;
      bad_digit   <= 1'b0;
    end else begin
      state       <= state_d;
      code        <= code_d;
      count       <= count_d;
      fail_count  <= fail_d;
      timer       <= timer_d;
      full        <= full_d;
      status      <= status_d;
      attempt_err <= err_d;
      bad_digit   <= bad_d;
    end
  end

`ifdef LOCKER_PIN_CHANGE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      pin_reg     <= DEFAULT_PIN;
      pin_changed <= 1'b0;
    end else begin
      pin_reg     <= pin_d;
      pin_changed <= pchg_d;
    end
  end
`endif

endmodule

// File: tb/tb_locker_access_controller.sv
module tb_locker_access_controller;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       key_ready;
  logic       key_enter = 1'b0;
  logic       key_clear = 1'b0;
  logic       relock = 1'b0;
  logic       unlocked, locked_out, attempt_err, bad_digit, pin_changed;
  logic [1:0] status, fail_count;

  int n_checks = 0;
  int n_fail   = 0;

  locker_access_controller dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_digit(key_digit),
    .key_ready(key_ready), .key_enter(key_enter), .key_clear(key_clear),
    .relock(relock), .unlocked(unlocked), .locked_out(locked_out),
    .status(status), .fail_count(fail_count), .attempt_err(attempt_err),
    .bad_digit(bad_digit), .pin_changed(pin_changed)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d; tick(); key_valid = 1'b0;
  endtask

  task automatic enter();
    key_enter = 1'b1; tick(); key_enter = 1'b0;
  endtask

  // Two digits then enter, then one more cycle so the CHECK result is visible.
  task automatic attempt(input logic [3:0] a, input logic [3:0] b);
    press(a); press(b); enter(); tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({key_ready, unlocked, locked_out, status, fail_count, attempt_err, bad_digit, pin_changed}
        !== {1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b unl=%b lo=%b st=%b fc=%0d err=%b bad=%b pc=%b, want rdy=1 others 0",
               key_ready, unlocked, locked_out, status, fail_count, attempt_err, bad_digit, pin_changed);
    end
  endtask

  task automatic test_correct_pin();
    int open_cycles;
    do_reset();
    press(4'd0); press(4'd3); enter();
    n_checks++;
    if (unlocked !== 1'b0) begin n_fail++; $display("FAIL open_latency_1: unlocked=%b want 0", unlocked); end
    tick();
    n_checks++;
    if (unlocked !== 1'b1 || status !== 2'b11) begin
      n_fail++; $display("FAIL open_latency_2: unlocked=%b status=%b want 1/11", unlocked, status);
    end
`ifndef LOCKER_PIN_CHANGE_EN
    n_checks++;
    if (key_ready !== 1'b0) begin n_fail++; $display("FAIL ready_in_open: key_ready=%b want 0", key_ready); end
`endif
    open_cycles = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (unlocked === 1'b1) open_cycles++;
    end
    n_checks++;
    if (open_cycles != 16) begin n_fail++; $display("FAIL open_duration: got %0d cycles want 16", open_cycles); end
    n_checks++;
    if (unlocked !== 1'b0 || status !== 2'b00 || key_ready !== 1'b1) begin
      n_fail++; $display("FAIL after_relock: unlocked=%b status=%b ready=%b want 0/00/1", unlocked, status, key_ready);
    end
  endtask

  task automatic test_lockout_master();
    do_reset();
    attempt(4'd1, 4'd2);
    n_checks++;
    if (attempt_err !== 1'b1 || fail_count !== 2'd1 || status !== 2'b00) begin
      n_fail++; $display("FAIL wrong_1: err=%b fc=%0d st=%b want 1/1/00", attempt_err, fail_count, status);
    end
    attempt(4'd4, 4'd5);
    n_checks++;
    if (attempt_err !== 1'b1 || fail_count !== 2'd2 || status !== 2'b01 || locked_out !== 1'b0) begin
      n_fail++; $display("FAIL wrong_2: err=%b fc=%0d st=%b lo=%b want 1/2/01/0", attempt_err, fail_count, status, locked_out);
    end
    attempt(4'd9, 4'd9);
    n_checks++;
    if (attempt_err !== 1'b1 || fail_count !== 2'd3 || status !== 2'b01 || locked_out !== 1'b1 || key_ready !== 1'b1) begin
      n_fail++; $display("FAIL wrong_3: err=%b fc=%0d st=%b lo=%b rdy=%b want 1/3/01/1/1",
                         attempt_err, fail_count, status, locked_out, key_ready);
    end
    // User PIN is not honoured in LOCKOUT.
    press(4'd0); press(4'd3); enter();
    n_checks++;
    if (locked_out !== 1'b1 || fail_count !== 2'd3 || attempt_err !== 1'b0 || unlocked !== 1'b0) begin
      n_fail++; $display("FAIL lockout_user_pin: lo=%b fc=%0d err=%b unl=%b want 1/3/0/0",
                         locked_out, fail_count, attempt_err, unlocked);
    end
    // Master release one cycle after enter.
    press(4'd8); press(4'd0); enter();
    n_checks++;
    if (status !== 2'b10 || locked_out !== 1'b0 || fail_count !== 2'd0) begin
      n_fail++; $display("FAIL master_release: st=%b lo=%b fc=%0d want 10/0/0", status, locked_out, fail_count);
    end
    tick();
    n_checks++;
    if (status !== 2'b00) begin n_fail++; $display("FAIL master_release_len: st=%b want 00", status); end
  endtask

  task automatic test_clear_precedence();
    do_reset();
    press(4'd0);
    key_clear = 1'b1; tick(); key_clear = 1'b0;
    press(4'd3); enter(); tick();
    n_checks++;
    if (attempt_err !== 1'b1 || fail_count !== 2'd1 || unlocked !== 1'b0) begin
      n_fail++; $display("FAIL clear_then_short: err=%b fc=%0d unl=%b want 1/1/0", attempt_err, fail_count, unlocked);
    end
    press(4'd0); press(4'd3);
    key_clear = 1'b1; key_enter = 1'b1; tick(); key_clear = 1'b0; key_enter = 1'b0;
    tick();
    n_checks++;
    if (attempt_err !== 1'b0 || fail_count !== 2'd1 || unlocked !== 1'b0) begin
      n_fail++; $display("FAIL clear_beats_enter: err=%b fc=%0d unl=%b want 0/1/0", attempt_err, fail_count, unlocked);
    end
    // Enter with a digit: the digit is dropped, so 0 + (enter & 3) is short.
    press(4'd0);
    key_valid = 1'b1; key_digit = 4'd3; key_enter = 1'b1; tick();
    key_valid = 1'b0; key_enter = 1'b0; tick();
    n_checks++;
    if (attempt_err !== 1'b1 || fail_count !== 2'd2 || unlocked !== 1'b0) begin
      n_fail++; $display("FAIL enter_beats_digit: err=%b fc=%0d unl=%b want 1/2/0", attempt_err, fail_count, unlocked);
    end
  endtask

  task automatic test_bad_digit_relock();
    do_reset();
    press(4'd0);
    press(4'hA);
    n_checks++;
    if (bad_digit !== 1'b1) begin n_fail++; $display("FAIL bad_digit_pulse: bad=%b want 1", bad_digit); end
    press(4'd3);
    n_checks++;
    if (bad_digit !== 1'b0) begin n_fail++; $display("FAIL bad_digit_len: bad=%b want 0", bad_digit); end
    enter(); tick();
    n_checks++;
    if (unlocked !== 1'b1 || attempt_err !== 1'b0) begin
      n_fail++; $display("FAIL bad_digit_open: unl=%b err=%b want 1/0", unlocked, attempt_err);
    end
    repeat (5) tick();  // timer now 5
    relock = 1'b1; tick(); relock = 1'b0;
    n_checks++;
    if (unlocked !== 1'b0 || status !== 2'b00) begin
      n_fail++; $display("FAIL relock: unl=%b st=%b want 0/00", unlocked, status);
    end
  endtask

  task automatic test_reset_in_lockout();
    do_reset();
    attempt(4'd1, 4'd1); attempt(4'd2, 4'd2); attempt(4'd7, 4'd7);
    n_checks++;
    if (locked_out !== 1'b1) begin n_fail++; $display("FAIL reach_lockout: lo=%b want 1", locked_out); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++;
    if (locked_out !== 1'b0 || fail_count !== 2'd0 || status !== 2'b00 || key_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_lockout: lo=%b fc=%0d st=%b rdy=%b want 0/0/00/1",
                         locked_out, fail_count, status, key_ready);
    end
  endtask

  task automatic test_pin_change();
`ifdef LOCKER_PIN_CHANGE_EN
    do_reset();
    attempt(4'd0, 4'd3);
    press(4'd4); press(4'd2); enter();
    n_checks++;
    if (pin_changed !== 1'b1 || unlocked !== 1'b1) begin
      n_fail++; $display("FAIL pin_changed: pc=%b unl=%b want 1/1", pin_changed, unlocked);
    end
    relock = 1'b1; tick(); relock = 1'b0;
    attempt(4'd0, 4'd3);
    n_checks++;
    if (attempt_err !== 1'b1 || unlocked !== 1'b0) begin
      n_fail++; $display("FAIL old_pin_rejected: err=%b unl=%b want 1/0", attempt_err, unlocked);
    end
    attempt(4'd4, 4'd2);
    n_checks++;
    if (unlocked !== 1'b1) begin n_fail++; $display("FAIL new_pin_opens: unl=%b want 1", unlocked); end
`else
    do_reset();
    attempt(4'd0, 4'd3);
    key_enter = 1'b1; tick(); key_enter = 1'b0;
    n_checks++;
    if (pin_changed !== 1'b0 || unlocked !== 1'b1) begin
      n_fail++; $display("FAIL no_pin_change: pc=%b unl=%b want 0/1", pin_changed, unlocked);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_correct_pin();
    test_lockout_master();
    test_clear_precedence();
    test_bad_digit_relock();
    test_reset_in_lockout();
    test_pin_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
